// File: rtl/riscv_pkg.sv
// Shared constants and types for the riscv32 memory-access stage.
// Holds opcodes, load/store funct3 encodings, the stage FSM states and the write-back bundle.
package riscv_pkg;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE,
        WAIT
    } mem_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        wb_en;
        logic [31:0] iw;
        logic [31:0] pc;
        logic        misalign;
    } wb_bundle_t;

    // Access size lives in funct3[1:0]; halfwords select their lane with off[1] only.
    function automatic logic [3:0] lane_enables(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3[1:0])
            2'b00:   lane_enables = 4'b0001 << off;
            2'b01:   lane_enables = 4'b0011 << {off[1], 1'b0};
            default: lane_enables = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_replicate(input logic [2:0] funct3, input logic [31:0] data);
        case (funct3[1:0])
            2'b00:   lane_replicate = {4{data[7:0]}};
            2'b01:   lane_replicate = {2{data[15:0]}};
            default: lane_replicate = data;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Load data alignment: picks the addressed byte or halfword lane out of the
// memory word and sign- or zero-extends it according to the load funct3.
module lsu_load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[7:0];
        case (off)
            2'd0: byte_lane = rdata[7:0];
            2'd1: byte_lane = rdata[15:8];
            2'd2: byte_lane = rdata[23:16];
            2'd3: byte_lane = rdata[31:24];
            default: byte_lane = rdata[7:0];
        endcase
        half_lane = off[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    data = {{24{byte_lane[7]}}, byte_lane};
            F3_H:    data = {{16{half_lane[15]}}, half_lane};
            F3_BU:   data = {24'h000000, byte_lane};
            F3_HU:   data = {16'h0000, half_lane};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// riscv32 memory-access stage: issues loads/stores on a req/ack port, aligns load data
// and registers the write-back bundle. Optional trap on misaligned access: MEM_MISALIGN_TRAP_EN.
module mem_stage
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] rs2_data_in,
    input  logic [31:0] iw_in,
    input  logic [31:0] pc_in,
    input  logic        w_en_in,
    input  logic        wb_en_in,
    input  logic [4:0]  wb_reg_in,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        valid_out,
    output logic [31:0] wb_data_out,
    output logic [4:0]  wb_reg_out,
    output logic        wb_en_out,
    output logic [31:0] iw_out,
    output logic [31:0] pc_out,
    output logic        misalign_out,
    output logic        df_mem_enable,
    output logic [4:0]  df_mem_reg,
    output logic [31:0] df_mem_data
);

    mem_state_t state, state_next;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [1:0]  off;
    logic        is_load;
    logic        is_store;
    logic        f3_legal;
    logic        is_misaligned;
    logic        capture;
    logic        ack_now;
    logic        mem_go;
    logic        pass_go;

    logic [31:0] req_alu;
    logic [31:0] req_wdata;
    logic [31:0] req_iw;
    logic [31:0] req_pc;
    logic [3:0]  req_be;
    logic        req_we;
    logic [4:0]  req_rd;
    logic        req_wb_en;

    logic [31:0] load_data;
    wb_bundle_t  pass_bundle;
    wb_bundle_t  mem_bundle;
    wb_bundle_t  out_q, out_next;
    wb_bundle_t  pend_q, pend_next;

    assign opcode    = iw_in[6:0];
    assign funct3    = iw_in[14:12];
    assign off       = alu_in[1:0];
    assign is_store  = w_en_in;
    assign is_load   = ~w_en_in & (opcode == LOAD);

    assign ack_now   = (state == WAIT) & dmem_ack;
    assign stall_out = (state == WAIT) & ~dmem_ack;
    assign capture   = valid_in & ~stall_out;

    always_comb begin
        f3_legal = 1'b0;
        if (is_store) begin
            f3_legal = funct3 inside {F3_B, F3_H, F3_W};
        end else if (is_load) begin
            f3_legal = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        is_misaligned = 1'b0;
        if ((is_load | is_store) & f3_legal) begin
            case (funct3[1:0])
                2'b01:   is_misaligned = off[0];
                2'b10:   is_misaligned = |off;
                default: is_misaligned = 1'b0;
            endcase
        end
    end
`else
    assign is_misaligned = 1'b0;
`endif

    // Illegal-funct3 and trapped accesses retire like pass-through, just without a register write.
    assign mem_go  = capture & (is_load | is_store) & f3_legal & ~is_misaligned;
    assign pass_go = capture & ~mem_go;

    always_comb begin
        pass_bundle          = '0;
        pass_bundle.valid    = 1'b1;
        pass_bundle.data     = alu_in;
        pass_bundle.rd       = wb_reg_in;
        pass_bundle.wb_en    = wb_en_in & ~(is_load | is_store);
        pass_bundle.iw       = iw_in;
        pass_bundle.pc       = pc_in;
        pass_bundle.misalign = is_misaligned;
    end

    lsu_load_extend u_load_extend (
        .rdata  (dmem_rdata),
        .off    (req_alu[1:0]),
        .funct3 (req_iw[14:12]),
        .data   (load_data)
    );

    always_comb begin
        mem_bundle          = '0;
        mem_bundle.valid    = 1'b1;
        mem_bundle.data     = req_we ? req_alu : load_data;
        mem_bundle.rd       = req_rd;
        mem_bundle.wb_en    = req_wb_en;
        mem_bundle.iw       = req_iw;
        mem_bundle.pc       = req_pc;
        mem_bundle.misalign = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (mem_go) state_next = WAIT;
            WAIT:    if (dmem_ack) state_next = mem_go ? WAIT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The request register only reloads on a new access, so dmem_* stays stable until ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_alu   <= '0;
            req_wdata <= '0;
            req_iw    <= '0;
            req_pc    <= '0;
            req_be    <= '0;
            req_we    <= 1'b0;
            req_rd    <= '0;
            req_wb_en <= 1'b0;
        end else if (mem_go) begin
            req_alu   <= alu_in;
            req_wdata <= lane_replicate(funct3, rs2_data_in);
            req_iw    <= iw_in;
            req_pc    <= pc_in;
            req_be    <= lane_enables(funct3, off);
            req_we    <= is_store;
            req_rd    <= wb_reg_in;
            req_wb_en <= is_store ? 1'b0 : wb_en_in;
        end
    end

    // A pass-through captured on the ack edge collides with the memory result for the
    // output register, so it parks in pend_q and retires on the following edge.
    always_comb begin
        out_next       = out_q;
        out_next.valid = 1'b0;
        pend_next      = pend_q;
        if (ack_now) begin
            out_next = mem_bundle;
            if (pass_go) begin
                pend_next = pass_bundle;
            end
        end else if (pend_q.valid) begin
            out_next  = pend_q;
            pend_next = pass_go ? pass_bundle : '0;
        end else if (pass_go) begin
            out_next = pass_bundle;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q  <= '0;
            pend_q <= '0;
        end else begin
            out_q  <= out_next;
            pend_q <= pend_next;
        end
    end

    assign dmem_req      = (state == WAIT);
    assign dmem_we       = req_we;
    assign dmem_addr     = {req_alu[31:2], 2'b00};
    assign dmem_wdata    = req_wdata;
    assign dmem_be       = req_be;

    assign valid_out     = out_q.valid;
    assign wb_data_out   = out_q.data;
    assign wb_reg_out    = out_q.rd;
    assign wb_en_out     = out_q.wb_en;
    assign iw_out        = out_q.iw;
    assign pc_out        = out_q.pc;
    assign misalign_out  = out_q.misalign;

    assign df_mem_enable = out_q.valid & out_q.wb_en;
    assign df_mem_reg    = out_q.rd;
    assign df_mem_data   = out_q.data;

endmodule

// File: tb/tb_mem_stage.sv
// Directed, table-driven bench for mem_stage: vector table for single transactions
// plus hand-written sequences for back-to-back issue and reset during an access.
module tb_mem_stage;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic [31:0] alu_in;
    logic [31:0] rs2_data_in;
    logic [31:0] iw_in;
    logic [31:0] pc_in;
    logic        w_en_in;
    logic        wb_en_in;
    logic [4:0]  wb_reg_in;
    logic        stall_out;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        valid_out;
    logic [31:0] wb_data_out;
    logic [4:0]  wb_reg_out;
    logic        wb_en_out;
    logic [31:0] iw_out;
    logic [31:0] pc_out;
    logic        misalign_out;
    logic        df_mem_enable;
    logic [4:0]  df_mem_reg;
    logic [31:0] df_mem_data;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [31:0] iw;
        logic [31:0] pc;
        logic        w_en;
        logic        wb_en;
        logic [4:0]  rd;
        int          delay;
        logic [31:0] rdata;
        logic        is_mem;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_we;
        logic        chk_data;
        logic [31:0] e_data;
        logic        e_wb_en;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];

    mem_stage dut (
        .clk           (clk),
        .reset         (reset),
        .valid_in      (valid_in),
        .alu_in        (alu_in),
        .rs2_data_in   (rs2_data_in),
        .iw_in         (iw_in),
        .pc_in         (pc_in),
        .w_en_in       (w_en_in),
        .wb_en_in      (wb_en_in),
        .wb_reg_in     (wb_reg_in),
        .stall_out     (stall_out),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_be       (dmem_be),
        .dmem_rdata    (dmem_rdata),
        .dmem_ack      (dmem_ack),
        .valid_out     (valid_out),
        .wb_data_out   (wb_data_out),
        .wb_reg_out    (wb_reg_out),
        .wb_en_out     (wb_en_out),
        .iw_out        (iw_out),
        .pc_out        (pc_out),
        .misalign_out  (misalign_out),
        .df_mem_enable (df_mem_enable),
        .df_mem_reg    (df_mem_reg),
        .df_mem_data   (df_mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_iw(input logic [2:0] f3, input logic [6:0] op);
        return {17'h00000, f3, 5'd0, op};
    endfunction

    function automatic vec_t mk_vec(input string name, input logic [31:0] alu, input logic [31:0] rs2,
                                    input logic [31:0] iw, input logic w_en, input logic wb_en,
                                    input logic [4:0] rd, input int delay, input logic [31:0] rdata,
                                    input logic is_mem, input logic [31:0] e_addr, input logic [3:0] e_be,
                                    input logic [31:0] e_wdata, input logic e_we, input logic chk_data,
                                    input logic [31:0] e_data, input logic e_wb_en, input logic e_mis);
        vec_t v;
        v.name = name;   v.alu = alu;       v.rs2 = rs2;     v.iw = iw;
        v.pc = 32'h0000_0100 + 32'(vecs.size() * 4);
        v.w_en = w_en;   v.wb_en = wb_en;   v.rd = rd;       v.delay = delay;
        v.rdata = rdata; v.is_mem = is_mem; v.e_addr = e_addr; v.e_be = e_be;
        v.e_wdata = e_wdata; v.e_we = e_we; v.chk_data = chk_data; v.e_data = e_data;
        v.e_wb_en = e_wb_en; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic idleInputs();
        valid_in    = 1'b0;
        w_en_in     = 1'b0;
        wb_en_in    = 1'b0;
        alu_in      = '0;
        rs2_data_in = '0;
        iw_in       = '0;
        pc_in       = '0;
        wb_reg_in   = '0;
    endtask

    task automatic applyStimulus(input vec_t v);
        int stalls;
        @(negedge clk);
        valid_in    = 1'b1;
        alu_in      = v.alu;
        rs2_data_in = v.rs2;
        iw_in       = v.iw;
        pc_in       = v.pc;
        w_en_in     = v.w_en;
        wb_en_in    = v.wb_en;
        wb_reg_in   = v.rd;
        @(posedge clk);
        @(negedge clk);
        idleInputs();
        if (v.is_mem) begin
            checkOutput({v.name, " dmem_req"}, 32'(dmem_req), 32'd1);
            checkOutput({v.name, " dmem_addr"}, dmem_addr, v.e_addr);
            checkOutput({v.name, " dmem_be"}, 32'(dmem_be), 32'(v.e_be));
            checkOutput({v.name, " dmem_we"}, 32'(dmem_we), 32'(v.e_we));
            if (v.e_we) checkOutput({v.name, " dmem_wdata"}, dmem_wdata, v.e_wdata);
            checkOutput({v.name, " bubble"}, 32'(valid_out), 32'd0);
            stalls = 0;
            for (int i = 0; i < v.delay; i++) begin
                if (stall_out) stalls++;
                @(posedge clk);
                @(negedge clk);
            end
            checkOutput({v.name, " stall cycles"}, 32'(stalls), 32'(v.delay));
            checkOutput({v.name, " addr held"}, dmem_addr, v.e_addr);
            dmem_ack   = 1'b1;
            dmem_rdata = v.rdata;
            #1;
            checkOutput({v.name, " stall on ack"}, 32'(stall_out), 32'd0);
            @(posedge clk);
            @(negedge clk);
            dmem_ack   = 1'b0;
            dmem_rdata = '0;
        end else begin
            checkOutput({v.name, " no req"}, 32'(dmem_req), 32'd0);
        end
        checkOutput({v.name, " valid_out"}, 32'(valid_out), 32'd1);
        checkOutput({v.name, " wb_en_out"}, 32'(wb_en_out), 32'(v.e_wb_en));
        checkOutput({v.name, " wb_reg_out"}, 32'(wb_reg_out), 32'(v.rd));
        checkOutput({v.name, " misalign_out"}, 32'(misalign_out), 32'(v.e_mis));
        checkOutput({v.name, " pc_out"}, pc_out, v.pc);
        checkOutput({v.name, " iw_out"}, iw_out, v.iw);
        checkOutput({v.name, " df_mem_enable"}, 32'(df_mem_enable), 32'(v.e_wb_en));
        if (v.chk_data) begin
            checkOutput({v.name, " wb_data_out"}, wb_data_out, v.e_data);
            checkOutput({v.name, " df_mem_data"}, df_mem_data, v.e_data);
        end
        @(negedge clk);
        checkOutput({v.name, " valid pulse"}, 32'(valid_out), 32'd0);
        checkOutput({v.name, " idle stall"}, 32'(stall_out), 32'd0);
    endtask

    initial begin
        idleInputs();
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        reset      = 1'b0;

        //          name       alu           rs2           iw                        w  wb rd dly rdata         mem addr          be       wdata         we chk data          wben mis
        vecs.push_back(mk_vec("ADD",  32'h0000_0010, 32'h0, mk_iw(3'b000, OP_ALU),   0, 1, 5, 0, 32'h0,         0, 32'h0,        4'b0000, 32'h0,        0, 1, 32'h0000_0010, 1, 0));
        vecs.push_back(mk_vec("SB",   32'h0000_1003, 32'hAB, mk_iw(3'b000, OP_STORE), 1, 0, 0, 3, 32'h0,        1, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 1, 0, 32'h0,         0, 0));
        vecs.push_back(mk_vec("LB",   32'h0000_2002, 32'h0, mk_iw(3'b000, OP_LOAD),  0, 1, 7, 0, 32'h0080_0000, 1, 32'h0000_2000, 4'b0100, 32'h0,        0, 1, 32'hFFFF_FF80, 1, 0));
        vecs.push_back(mk_vec("LBU",  32'h0000_2002, 32'h0, mk_iw(3'b100, OP_LOAD),  0, 1, 8, 0, 32'h0080_0000, 1, 32'h0000_2000, 4'b0100, 32'h0,        0, 1, 32'h0000_0080, 1, 0));
        vecs.push_back(mk_vec("LHU",  32'h0000_3002, 32'h0, mk_iw(3'b101, OP_LOAD),  0, 1, 9, 1, 32'hBEEF_0000, 1, 32'h0000_3000, 4'b1100, 32'h0,        0, 1, 32'h0000_BEEF, 1, 0));
        vecs.push_back(mk_vec("LH",   32'h0000_3000, 32'h0, mk_iw(3'b001, OP_LOAD),  0, 1, 10, 1, 32'h0000_8001, 1, 32'h0000_3000, 4'b0011, 32'h0,       0, 1, 32'hFFFF_8001, 1, 0));
        vecs.push_back(mk_vec("LW",   32'h0000_4000, 32'h0, mk_iw(3'b010, OP_LOAD),  0, 1, 11, 2, 32'h1234_5678, 1, 32'h0000_4000, 4'b1111, 32'h0,       0, 1, 32'h1234_5678, 1, 0));
        vecs.push_back(mk_vec("SH",   32'h0000_5002, 32'h1234_CAFE, mk_iw(3'b001, OP_STORE), 1, 0, 0, 0, 32'h0, 1, 32'h0000_5000, 4'b1100, 32'hCAFE_CAFE, 1, 0, 32'h0,         0, 0));
        vecs.push_back(mk_vec("SW",   32'h0000_6000, 32'hDEAD_BEEF, mk_iw(3'b010, OP_STORE), 1, 0, 0, 1, 32'h0, 1, 32'h0000_6000, 4'b1111, 32'hDEAD_BEEF, 1, 0, 32'h0,         0, 0));
        vecs.push_back(mk_vec("LDBAD", 32'h0000_0077, 32'h0, mk_iw(3'b011, OP_LOAD), 0, 1, 12, 0, 32'h0,         0, 32'h0,        4'b0000, 32'h0,        0, 1, 32'h0000_0077, 0, 0));
        vecs.push_back(mk_vec("STBAD", 32'h0000_0088, 32'h55, mk_iw(3'b100, OP_STORE), 1, 0, 13, 0, 32'h0,      0, 32'h0,        4'b0000, 32'h0,        0, 1, 32'h0000_0088, 0, 0));
        vecs.push_back(mk_vec("X0",   32'h0000_0099, 32'h0, mk_iw(3'b000, OP_ALU),   0, 1, 0, 0, 32'h0,         0, 32'h0,        4'b0000, 32'h0,        0, 1, 32'h0000_0099, 1, 0));
`ifdef MEM_MISALIGN_TRAP_EN
        vecs.push_back(mk_vec("LWMIS", 32'h0000_1002, 32'h0, mk_iw(3'b010, OP_LOAD), 0, 1, 14, 0, 32'h0,         0, 32'h0,        4'b0000, 32'h0,        0, 1, 32'h0000_1002, 0, 1));
`else
        vecs.push_back(mk_vec("LWMIS", 32'h0000_1002, 32'h0, mk_iw(3'b010, OP_LOAD), 0, 1, 14, 0, 32'hCAFE_F00D, 1, 32'h0000_1000, 4'b1111, 32'h0,     0, 1, 32'hCAFE_F00D, 1, 0));
`endif

        repeat (2) @(negedge clk);
        checkOutput("reset valid_out", 32'(valid_out), 32'd0);
        checkOutput("reset dmem_req", 32'(dmem_req), 32'd0);
        checkOutput("reset stall_out", 32'(stall_out), 32'd0);
        checkOutput("reset wb_data_out", wb_data_out, 32'd0);
        checkOutput("reset dmem_addr", dmem_addr, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
        end

        // LW acked in its first WAIT cycle while an ADD is offered: two retirements in a row.
        @(negedge clk);
        valid_in = 1'b1; alu_in = 32'h0000_4004; iw_in = mk_iw(3'b010, OP_LOAD);
        wb_en_in = 1'b1; wb_reg_in = 5'd3; pc_in = 32'h0000_0200;
        @(posedge clk);
        @(negedge clk);
        checkOutput("b2b dmem_req", 32'(dmem_req), 32'd1);
        alu_in = 32'h0000_0055; iw_in = mk_iw(3'b000, OP_ALU); wb_reg_in = 5'd9; pc_in = 32'h0000_0204;
        dmem_ack = 1'b1; dmem_rdata = 32'hA5A5_0F0F;
        #1;
        checkOutput("b2b stall on ack", 32'(stall_out), 32'd0);
        @(posedge clk);
        @(negedge clk);
        idleInputs();
        dmem_ack = 1'b0; dmem_rdata = '0;
        checkOutput("b2b first valid", 32'(valid_out), 32'd1);
        checkOutput("b2b first data", wb_data_out, 32'hA5A5_0F0F);
        checkOutput("b2b first reg", 32'(wb_reg_out), 32'd3);
        checkOutput("b2b req dropped", 32'(dmem_req), 32'd0);
        @(negedge clk);
        checkOutput("b2b second valid", 32'(valid_out), 32'd1);
        checkOutput("b2b second data", wb_data_out, 32'h0000_0055);
        checkOutput("b2b second reg", 32'(df_mem_reg), 32'd9);
        @(negedge clk);
        checkOutput("b2b drained", 32'(valid_out), 32'd0);

        // Two pass-through instructions back to back retire on consecutive cycles.
        valid_in = 1'b1; alu_in = 32'h0000_0111; iw_in = mk_iw(3'b000, OP_ALU); wb_en_in = 1'b1; wb_reg_in = 5'd1;
        @(posedge clk);
        @(negedge clk);
        alu_in = 32'h0000_0222; wb_reg_in = 5'd2;
        checkOutput("burst first", wb_data_out, 32'h0000_0111);
        @(posedge clk);
        @(negedge clk);
        idleInputs();
        checkOutput("burst second valid", 32'(valid_out), 32'd1);
        checkOutput("burst second", wb_data_out, 32'h0000_0222);

        // Reset in the middle of an access: everything clears at once and a late ack is ignored.
        @(negedge clk);
        valid_in = 1'b1; alu_in = 32'h0000_7000; iw_in = mk_iw(3'b010, OP_LOAD); wb_en_in = 1'b1; wb_reg_in = 5'd4;
        @(posedge clk);
        @(negedge clk);
        idleInputs();
        checkOutput("rst wait dmem_req", 32'(dmem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("rst async dmem_req", 32'(dmem_req), 32'd0);
        checkOutput("rst async stall", 32'(stall_out), 32'd0);
        checkOutput("rst async dmem_addr", dmem_addr, 32'd0);
        checkOutput("rst async wb_data", wb_data_out, 32'd0);
        checkOutput("rst async df_enable", 32'(df_mem_enable), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
        @(posedge clk);
        @(negedge clk);
        dmem_ack = 1'b0; dmem_rdata = '0;
        checkOutput("late ack valid", 32'(valid_out), 32'd0);
        checkOutput("late ack req", 32'(dmem_req), 32'd0);
        @(negedge clk);
        checkOutput("late ack quiet", 32'(valid_out), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
